// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared AES-128 definitions: FSM states, S-box, round constants and GF(2^8) xtime.
package aes128_encrypt_iter_pkg;

    typedef enum logic {IDLE, ROUND} state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Element 0 sits in the most significant byte, so SBOX[b] is a direct lookup.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: produces the next round key from the current one.
module aes_key_step
    import aes128_encrypt_iter_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] next_rk
);

    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] sub_rot;

    assign {w0, w1, w2, w3} = rk;

    // RotWord then SubWord on w3, folded into one set of four lookups.
    assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign w4 = w0 ^ sub_rot ^ {rcon, 24'h0};
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;

    assign next_rk = {w4, w5, w6, w7};

endmodule

// File: rtl/sub_bytes.sv
// Byte-wise S-box substitution across the full 128-bit AES state.
module sub_bytes
    import aes128_encrypt_iter_pkg::*;
(
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one full round per clock, ciphertext after ten rounds.
module aes128_encrypt_iter
    import aes128_encrypt_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic [127:0] ct,
    output logic         busy,
    output logic         done
);

    state_e       fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] sb_out, sr_out, mc_out, next_rk, round_out;

    // Byte i of the state is row i%4, column i/4 (column-major, byte 0 in the MSBs).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    sub_bytes u_sub_bytes (
        .data_i (state_q),
        .data_o (sb_out)
    );

    aes_key_step u_key_step (
        .rk      (rk_q),
        .rcon    (rcon(rnd_q)),
        .next_rk (next_rk)
    );

    assign sr_out    = shift_rows(sb_out);
    assign mc_out    = mix_columns(sr_out);
    assign round_out = ((rnd_q == LAST_ROUND) ? sr_out : mc_out) ^ next_rk;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = pt ^ key;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out;
                rk_d    = next_rk;
                if (rnd_q == LAST_ROUND) begin
                    ct_d   = round_out;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
        busy_d = (fsm_d == ROUND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ct   = ct_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed-vector bench for the iterative AES-128 encryptor using FIPS-197 known answers.
module tb_aes128_encrypt_iter;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] S1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    aes128_encrypt_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .pt    (pt),
        .ct    (ct),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents inputs with start, lets the accepting edge pass, and returns at the following negedge.
    task automatic start_op(input logic [127:0] k, input logic [127:0] p, input bit hold);
        @(negedge clk);
        key   = k;
        pt    = p;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Counts rising edges (accepting edge = 1) until done is seen; gives up at 40.
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ct !== 128'h0) begin errors++; $display("[TB] FAIL reset_ct: got %h expected %h", ct, 128'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (dut.state_q !== 128'h0) begin errors++; $display("[TB] FAIL reset_state: got %h expected 0", dut.state_q); end
        checks++; if (dut.rnd_q !== 4'd0) begin errors++; $display("[TB] FAIL reset_rnd: got %0d expected 0", dut.rnd_q); end
        rst = 1'b0;
    endtask

    task automatic test_vector1();
        int e;
        start_op(K1, P1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL v1_busy: got %b expected 1", busy); end
        checks++; if (dut.state_q !== S1) begin errors++; $display("[TB] FAIL v1_init_xor: got %h expected %h", dut.state_q, S1); end
        checks++; if (dut.rnd_q !== 4'd1) begin errors++; $display("[TB] FAIL v1_rnd: got %0d expected 1", dut.rnd_q); end
        wait_done(1, e);
        checks++; if (e !== 11) begin errors++; $display("[TB] FAIL v1_latency: got %0d expected 11", e); end
        checks++; if (ct !== C1) begin errors++; $display("[TB] FAIL v1_ct: got %h expected %h", ct, C1); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL v1_done_width: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL v1_idle_busy: got %b expected 0", busy); end
        checks++; if (ct !== C1) begin errors++; $display("[TB] FAIL v1_ct_hold: got %h expected %h", ct, C1); end
    endtask

    task automatic test_vector2();
        int e;
        start_op(K2, P2, 1'b0);
        wait_done(1, e);
        checks++; if (e !== 11) begin errors++; $display("[TB] FAIL v2_latency: got %0d expected 11", e); end
        checks++; if (ct !== C2) begin errors++; $display("[TB] FAIL v2_ct: got %h expected %h", ct, C2); end
    endtask

    task automatic test_start_ignored();
        int e;
        int pulses;
        int busy_seen;
        start_op(K1, P1, 1'b0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++; if (dut.rnd_q !== 4'd4) begin errors++; $display("[TB] FAIL ign_rnd: got %0d expected 4", dut.rnd_q); end
        start = 1'b1;
        key   = K2;
        pt    = P2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(5, e);
        checks++; if (e !== 11) begin errors++; $display("[TB] FAIL ign_latency: got %0d expected 11", e); end
        checks++; if (ct !== C1) begin errors++; $display("[TB] FAIL ign_ct: got %h expected %h", ct, C1); end
        pulses    = 0;
        busy_seen = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (busy === 1'b1) busy_seen++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL ign_extra_done: got %0d expected 0", pulses); end
        checks++; if (busy_seen !== 0) begin errors++; $display("[TB] FAIL ign_second_op: got %0d expected 0", busy_seen); end
    endtask

    task automatic test_reset_abort();
        int e;
        int pulses;
        start_op(K1, P1, 1'b0);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        checks++; if (dut.rnd_q !== 4'd6) begin errors++; $display("[TB] FAIL abort_rnd: got %0d expected 6", dut.rnd_q); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (ct !== 128'h0) begin errors++; $display("[TB] FAIL abort_ct: got %h expected 0", ct); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d expected 0", pulses); end
        checks++; if (ct !== 128'h0) begin errors++; $display("[TB] FAIL abort_ct_hold: got %h expected 0", ct); end
        start_op(K2, P2, 1'b0);
        wait_done(1, e);
        checks++; if (ct !== C2) begin errors++; $display("[TB] FAIL abort_rerun_ct: got %h expected %h", ct, C2); end
    endtask

    task automatic test_back_to_back();
        int e;
        int gap;
        start_op(K1, P1, 1'b1);
        key = K2;
        pt  = P2;
        wait_done(1, e);
        checks++; if (e !== 11) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 11", e); end
        checks++; if (ct !== C1) begin errors++; $display("[TB] FAIL b2b_ct1: got %h expected %h", ct, C1); end
        gap = 0;
        do begin
            @(posedge clk);
            gap++;
            @(negedge clk);
        end while (done !== 1'b1 && gap < 40);
        start = 1'b0;
        checks++; if (gap !== 11) begin errors++; $display("[TB] FAIL b2b_gap: got %0d expected 11", gap); end
        checks++; if (ct !== C2) begin errors++; $display("[TB] FAIL b2b_ct2: got %h expected %h", ct, C2); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stop: got %b expected 0", busy); end
    endtask

    task automatic test_input_change();
        int e;
        start_op(K2, P2, 1'b0);
        e = 1;
        while (done !== 1'b1 && e < 40) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        checks++; if (e !== 11) begin errors++; $display("[TB] FAIL rand_latency: got %0d expected 11", e); end
        checks++; if (ct !== C2) begin errors++; $display("[TB] FAIL rand_ct: got %h expected %h", ct, C2); end
        repeat (4) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (ct !== C2) begin errors++; $display("[TB] FAIL rand_ct_hold: got %h expected %h", ct, C2); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        pt    = '0;
        test_reset();
        test_vector1();
        test_vector2();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_input_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
